// File: rtl/ula_exec_stage.sv
// Issue/writeback stage around a combinational 32-bit ULA: a 16x32 register file, a single
// execute slot and result forwarding. Optional macro ULA_EXEC_FLAGS_EN adds N/Z result flags.
module ula_exec_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic              cmd_use_imm,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic [ADDR_W-1:0] cmd_rd,
    output logic [DATA_W-1:0] ula_a,
    output logic [DATA_W-1:0] ula_b,
    output logic [1:0]        ula_ctrl,
    input  logic [DATA_W-1:0] ula_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] res_rd,
`ifdef ULA_EXEC_FLAGS_EN
    output logic [1:0]        res_flags,
`endif
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ula_a_q, ula_a_d;
    logic [DATA_W-1:0] ula_b_q, ula_b_d;
    logic [1:0]        ula_ctrl_q, ula_ctrl_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  wr_en;
    logic              accept;
    logic              retire;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    assign cmd_ready = !ex_valid_q || res_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign retire    = ex_valid_q && res_ready;

    assign res_valid = ex_valid_q;
    assign res_data  = ula_y;
    assign res_rd    = ex_rd_q;
    assign ula_a     = ula_a_q;
    assign ula_b     = ula_b_q;
    assign ula_ctrl  = ula_ctrl_q;

    // Register 0 is hardwired to zero, so its write enable never fires.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_en
            assign wr_en[gi] = retire && (ex_rd_q == ADDR_W'(gi)) && (gi != 0);
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = wr_en[i] ? ula_y : regs_q[i];
        end
    end

    // The retiring result bypasses the register file for a back-to-back dependent command.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (cmd_ra != '0) begin
            op_a = (retire && ex_rd_q == cmd_ra) ? ula_y : regs_q[cmd_ra];
        end
        if (cmd_rb != '0) begin
            op_b = (retire && ex_rd_q == cmd_rb) ? ula_y : regs_q[cmd_rb];
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rd_d    = ex_rd_q;
        ula_a_d    = ula_a_q;
        ula_b_d    = ula_b_q;
        ula_ctrl_d = ula_ctrl_q;
        if (accept) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = cmd_rd;
            ula_a_d    = op_a;
            ula_b_d    = cmd_use_imm ? cmd_imm : op_b;
            ula_ctrl_d = cmd_op;
        end else if (retire) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            ula_a_q    <= '0;
            ula_b_q    <= '0;
            ula_ctrl_q <= 2'b00;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            ula_a_q    <= ula_a_d;
            ula_b_q    <= ula_b_d;
            ula_ctrl_q <= ula_ctrl_d;
            regs_q     <= regs_d;
        end
    end

`ifdef ULA_EXEC_FLAGS_EN
    logic [1:0] flags_q, flags_d;

    assign res_flags = {ula_y[DATA_W-1], (ula_y == '0)};

    always_comb begin
        flags_d = retire ? res_flags : flags_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 2'b00;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Address 0 exposes the last retired flags in place of the constant zero.
    always_comb begin
        dbg_data = regs_q[dbg_addr];
        if (dbg_addr == '0) begin
            dbg_data = {{(DATA_W-2){1'b0}}, flags_q};
        end
    end
`else
    always_comb begin
        dbg_data = regs_q[dbg_addr];
        if (dbg_addr == '0) begin
            dbg_data = '0;
        end
    end
`endif

endmodule

// File: tb/tb_ula_exec_stage.sv
// Bench for ula_exec_stage: directed scenarios plus random traffic, scored against an
// in-order architectural model (speculative registers at accept, committed at retire).
module tb_ula_exec_stage;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_ra;
    logic [AW-1:0] cmd_rb;
    logic          cmd_use_imm;
    logic [DW-1:0] cmd_imm;
    logic [AW-1:0] cmd_rd;
    logic [DW-1:0] ula_a;
    logic [DW-1:0] ula_b;
    logic [1:0]    ula_ctrl;
    logic [DW-1:0] ula_y;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_rd;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
`ifdef ULA_EXEC_FLAGS_EN
    logic [1:0]    res_flags;
`endif

    always #5 clk = ~clk;

    ula_exec_stage #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_use_imm(cmd_use_imm),
        .cmd_imm(cmd_imm), .cmd_rd(cmd_rd),
        .ula_a(ula_a), .ula_b(ula_b), .ula_ctrl(ula_ctrl), .ula_y(ula_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd),
`ifdef ULA_EXEC_FLAGS_EN
        .res_flags(res_flags),
`endif
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // The combinational ULA the stage drives.
    always_comb begin
        case (ula_ctrl)
            2'b00:   ula_y = ula_a + ula_b;
            2'b01:   ula_y = ula_a - ula_b;
            2'b10:   ula_y = ula_a & ula_b;
            default: ula_y = ula_a | ula_b;
        endcase
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
    } res_t;

    res_t          exp_q[$];
    logic [DW-1:0] arch_r [NR];
    logic [DW-1:0] commit_r [NR];
    logic [1:0]    commit_flags;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            last_accept = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] alu(input logic [1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [1:0] flags_of(input logic [DW-1:0] d);
        return {d[DW-1], d == '0};
    endfunction

    function automatic logic [DW-1:0] arch_read(input logic [AW-1:0] a);
        return (a == '0) ? '0 : arch_r[a];
    endfunction

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            arch_r[i]   = '0;
            commit_r[i] = '0;
        end
        commit_flags = 2'b00;
    endtask

    // One clock cycle: check outputs at the falling edge, update the model at the rising edge.
    task automatic step();
        bit            empty;
        bit            acc;
        bit            ret;
        res_t          e;
        logic [DW-1:0] b;
        acc = 0;
        ret = 0;
        e   = '0;
        @(negedge clk);
        last_accept = 0;
        if (rst_n) begin
            empty = (exp_q.size() == 0);
            check("res_valid", {31'b0, res_valid}, {31'b0, !empty});
            check("cmd_ready", {31'b0, cmd_ready}, {31'b0, empty || res_ready});
            if (!empty) begin
                check("res_data", res_data, exp_q[0].data);
                check("res_rd", {28'b0, res_rd}, {28'b0, exp_q[0].rd});
`ifdef ULA_EXEC_FLAGS_EN
                check("res_flags", {30'b0, res_flags}, {30'b0, flags_of(exp_q[0].data)});
`endif
            end
            acc = cmd_valid && (empty || res_ready);
            ret = !empty && res_ready;
            if (ret) e = exp_q.pop_front();
            if (acc) begin
                b = cmd_use_imm ? cmd_imm : arch_read(cmd_rb);
                exp_q.push_back('{data: alu(cmd_op, arch_read(cmd_ra), b), rd: cmd_rd});
                if (cmd_rd != '0) arch_r[cmd_rd] = exp_q[exp_q.size()-1].data;
                last_accept = 1;
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else if (ret) begin
            if (e.rd != '0) commit_r[e.rd] = e.data;
            commit_flags = flags_of(e.data);
        end
        #1;
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic use_imm, input logic [DW-1:0] imm, input logic [AW-1:0] rd);
        cmd_valid = 1; cmd_op = op; cmd_ra = ra; cmd_rb = rb;
        cmd_use_imm = use_imm; cmd_imm = imm; cmd_rd = rd;
        for (int k = 0; k < 50; k++) begin
            step();
            if (last_accept) break;
        end
        check("issue_accepted", {31'b0, last_accept}, 32'd1);
        cmd_valid = 0;
    endtask

    task automatic drain();
        res_ready = 1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic dbg_expect(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic dbg_all(input string tag);
        logic [DW-1:0] exp;
        for (int a = 0; a < NR; a++) begin
            exp = commit_r[a];
`ifdef ULA_EXEC_FLAGS_EN
            if (a == 0) exp = {30'b0, commit_flags};
`endif
            dbg_expect($sformatf("%s_R%0d", tag, a), AW'(a), exp);
        end
        realign();
    endtask

    initial begin
        clear_model();
        rst_n = 0; res_ready = 1; dbg_addr = '0;
        cmd_valid = 1; cmd_op = 2'b01; cmd_ra = 4'd3; cmd_rb = 4'd4;
        cmd_use_imm = 1; cmd_imm = 32'h1234; cmd_rd = 4'd5;

        // Reset held two cycles with a command offered.
        step(); step();
        rst_n = 1; cmd_valid = 0;
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_ula_ctrl", {30'b0, ula_ctrl}, 32'd0);
        check("rst_ula_a", ula_a, 32'd0);
        dbg_all("rst");

        // Immediate loads.
        issue(2'b00, 4'd0, 4'd0, 1, 32'd5, 4'd1);
        issue(2'b00, 4'd0, 4'd0, 1, 32'd7, 4'd2);
        drain();
        dbg_expect("load_R1", 4'd1, 32'd5);
        dbg_expect("load_R2", 4'd2, 32'd7);
        realign();

        // Back-to-back dependent commands.
        issue(2'b01, 4'd2, 4'd1, 0, 32'd0, 4'd3);
        issue(2'b00, 4'd3, 4'd3, 0, 32'd0, 4'd4);
        drain();
        dbg_expect("fwd_R3", 4'd3, 32'd2);
        dbg_expect("fwd_R4", 4'd4, 32'd4);
        realign();

        // Wrap, logic ops and a write to R0.
        issue(2'b00, 4'd0, 4'd0, 1, 32'd0, 4'd1);
        issue(2'b01, 4'd0, 4'd0, 1, 32'd1, 4'd5);
        issue(2'b10, 4'd5, 4'd0, 1, 32'h0F0F_0F0F, 4'd8);
        issue(2'b11, 4'd0, 4'd0, 1, 32'hA000_0000, 4'd9);
        issue(2'b00, 4'd0, 4'd0, 1, 32'h33, 4'd0);
        drain();
        dbg_expect("wrap_R5", 4'd5, 32'hFFFF_FFFF);
        dbg_expect("and_R8", 4'd8, 32'h0F0F_0F0F);
        dbg_expect("or_R9", 4'd9, 32'hA000_0000);
        realign();
        dbg_all("ops");

        // Backpressure with a dependent command waiting.
        issue(2'b00, 4'd0, 4'd0, 1, 32'h12, 4'd7);
        res_ready = 0;
        cmd_valid = 1; cmd_op = 2'b00; cmd_ra = 4'd7; cmd_rb = 4'd0;
        cmd_use_imm = 1; cmd_imm = 32'd1; cmd_rd = 4'd10;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_no_accept", {31'b0, last_accept}, 32'd0);
            check("bp_hold_data", res_data, 32'h12);
        end
        dbg_expect("bp_no_wb_R7", 4'd7, 32'd0);
        realign();
        res_ready = 1;
        step();
        check("bp_release_accept", {31'b0, last_accept}, 32'd1);
        cmd_valid = 0;
        drain();
        dbg_expect("bp_R7", 4'd7, 32'h12);
        dbg_expect("bp_R10", 4'd10, 32'h13);
        realign();

        // Reset while a command is in flight.
        issue(2'b00, 4'd0, 4'd0, 1, 32'h55, 4'd6);
        rst_n = 0;
        step();
        rst_n = 1;
        check("midrst_res_valid", {31'b0, res_valid}, 32'd0);
        dbg_expect("midrst_R6", 4'd6, 32'd0);
        realign();

`ifdef ULA_EXEC_FLAGS_EN
        issue(2'b01, 4'd0, 4'd0, 1, 32'd0, 4'd11);
        check("flags_zero", {30'b0, res_flags}, 32'd1);
        issue(2'b00, 4'd0, 4'd0, 1, 32'hFFFF_FFFF, 4'd12);
        check("flags_neg", {30'b0, res_flags}, 32'd2);
        drain();
        dbg_expect("flags_reg", 4'd0, 32'd2);
        realign();
`endif

        // Random traffic with random backpressure; an unaccepted command is held stable.
        cmd_valid = 0;
        for (int c = 0; c < 400; c++) begin
            if (!(cmd_valid && !last_accept)) begin
                cmd_valid   = ($urandom_range(0, 3) != 0);
                cmd_op      = 2'($urandom_range(0, 3));
                cmd_ra      = AW'($urandom_range(0, NR-1));
                cmd_rb      = AW'($urandom_range(0, NR-1));
                cmd_use_imm = $urandom_range(0, 1) == 1;
                cmd_imm     = $urandom;
                cmd_rd      = AW'($urandom_range(0, NR-1));
            end
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        cmd_valid = 0;
        drain();
        dbg_all("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
